// File: rtl/man_framer.sv
// Manchester bit-stream framer: hunts for a sync word, reads a length byte,
// then assembles payload bytes into a first-word-fall-through output FIFO.
module man_framer #(
  parameter logic [15:0] SYNC_WORD  = 16'hA5C3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] man_bits,
  input  logic [1:0] man_bits_n,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_active,
  output logic       overflow,
  output logic       proto_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {HUNT, LEN, DATA} state_t;

  state_t      state, state_nx;
  logic [15:0] sync_q, sync_nx;
  logic [7:0]  shift_q, shift_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  rem_q, rem_nx;
  logic [1:0]  nbits;
  logic        cur;
  logic        done;
  logic        push;
  logic [8:0]  push_entry;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en;

  // Walk the cycle's bits one at a time so a state change can land between them
  always_comb begin
    state_nx   = state;
    sync_nx    = sync_q;
    shift_nx   = shift_q;
    bit_cnt_nx = bit_cnt;
    rem_nx     = rem_q;
    push       = 1'b0;
    push_entry = '0;
    done       = 1'b0;
    cur        = 1'b0;
    nbits      = (man_bits_n == 2'd3) ? 2'd0 : man_bits_n;
    for (int i = 0; i < 2; i++) begin
      if ((2'(i) < nbits) && !done) begin
        cur = man_bits[i];
        unique case (state_nx)
          HUNT: begin
            sync_nx = {sync_nx[14:0], cur};
            if (sync_nx == SYNC_WORD) begin
              state_nx   = LEN;
              bit_cnt_nx = '0;
              shift_nx   = '0;
            end
          end
          LEN: begin
            shift_nx = {shift_nx[6:0], cur};
            if (bit_cnt_nx == 3'd7) begin
              bit_cnt_nx = '0;
              if (shift_nx == 8'd0) begin
                state_nx = HUNT;
                sync_nx  = '0;
              end else begin
                state_nx = DATA;
                rem_nx   = shift_nx;
              end
            end else begin
              bit_cnt_nx = bit_cnt_nx + 3'd1;
            end
          end
          DATA: begin
            shift_nx = {shift_nx[6:0], cur};
            if (bit_cnt_nx == 3'd7) begin
              bit_cnt_nx = '0;
              push       = 1'b1;
              push_entry = {(rem_nx == 8'd1), shift_nx};
              if (rem_nx == 8'd1) begin
                // frame over: any later bit this cycle is thrown away
                state_nx = HUNT;
                sync_nx  = '0;
                done     = 1'b1;
              end
              rem_nx = rem_nx - 8'd1;
            end else begin
              bit_cnt_nx = bit_cnt_nx + 3'd1;
            end
          end
          default: state_nx = HUNT;
        endcase
      end
    end
  end

  // Framing state, counters and sticky flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= HUNT;
      sync_q       <= '0;
      shift_q      <= '0;
      bit_cnt      <= '0;
      rem_q        <= '0;
      frame_active <= 1'b0;
      overflow     <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state        <= state_nx;
      sync_q       <= sync_nx;
      shift_q      <= shift_nx;
      bit_cnt      <= bit_cnt_nx;
      rem_q        <= rem_nx;
      frame_active <= (state_nx != HUNT);
      if (push && full && !pop) overflow <= 1'b1;
      if (man_bits_n == 2'd3) proto_err <= 1'b1;
    end
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = m_axis_tvalid && m_axis_tready;
  assign wr_en = push && (!full || pop);

  assign m_axis_tvalid = (count != '0);
  assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_man_framer.sv
// Directed bench for man_framer with a queue scoreboard and an independent monitor.
module tb_man_framer;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [1:0] man_bits;
  logic [1:0] man_bits_n;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       frame_active;
  logic       overflow;
  logic       proto_err;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb [$];
  bit         bq [$];
  logic [8:0] mon_exp;

  man_framer #(.SYNC_WORD(16'hA5C3), .FIFO_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .man_bits(man_bits), .man_bits_n(man_bits_n),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .frame_active(frame_active), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output beat against the scoreboard head
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h expected none", {m_axis_tlast, m_axis_tdata});
      end else begin
        mon_exp = sb.pop_front();
        check("stream_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(mon_exp));
      end
    end
  end

  task automatic expect_beat(input logic [7:0] d, input logic l);
    sb.push_back({l, d});
  endtask

  task automatic add_byte(input logic [7:0] x);
    for (int i = 7; i >= 0; i--) bq.push_back(x[i]);
  endtask

  task automatic add_bit(input bit b);
    bq.push_back(b);
  endtask

  task automatic cyc(input logic [1:0] b, input logic [1:0] n);
    man_bits   = b;
    man_bits_n = n;
    @(posedge aclk);
    #1;
    man_bits   = 2'b00;
    man_bits_n = 2'd0;
  endtask

  // mode 2: two bits per cycle; mode 1: one bit then an idle cycle
  task automatic flush(input int mode);
    bit b0, b1;
    if (mode == 2) begin
      while (bq.size() >= 2) begin
        b0 = bq.pop_front();
        b1 = bq.pop_front();
        cyc({b1, b0}, 2'd2);
      end
      if (bq.size() == 1) begin
        b0 = bq.pop_front();
        cyc({1'b0, b0}, 2'd1);
      end
    end else begin
      while (bq.size() > 0) begin
        b0 = bq.pop_front();
        cyc({1'b0, b0}, 2'd1);
        cyc(2'b00, 2'd0);
      end
    end
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge aclk);
    @(posedge aclk);
    #1;
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_tvalid_low"}, 32'(m_axis_tvalid), 32'd0);
  endtask

  task automatic add_frame_hdr(input logic [7:0] len);
    add_byte(8'hA5);
    add_byte(8'hC3);
    add_byte(len);
  endtask

  initial begin
    aresetn       = 1'b0;
    man_bits      = 2'b00;
    man_bits_n    = 2'd0;
    m_axis_tready = 1'b1;
    #2;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_flags", 32'({overflow, proto_err}), 32'd0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Basic frame, two bits per cycle
    add_frame_hdr(8'h02); add_byte(8'h11); add_byte(8'h22);
    expect_beat(8'h11, 1'b0); expect_beat(8'h22, 1'b1);
    flush(2);
    check("basic_last_latency", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'h322);
    check("basic_frame_active_fell", 32'(frame_active), 32'd0);
    wait_empty("basic");

    // Same frame, one bit per cycle with idle gaps and a junk prefix bit
    add_bit(1'b1); add_frame_hdr(8'h02); add_byte(8'h11); add_byte(8'h22);
    expect_beat(8'h11, 1'b0); expect_beat(8'h22, 1'b1);
    flush(1);
    wait_empty("slow");

    // Odd alignment at two bits per cycle
    add_bit(1'b0); add_frame_hdr(8'h02); add_byte(8'h11); add_byte(8'h22);
    expect_beat(8'h11, 1'b0); expect_beat(8'h22, 1'b1);
    flush(2);
    wait_empty("odd_align");

    // Zero-length frame, then an immediate one-byte frame
    add_frame_hdr(8'h00);
    add_frame_hdr(8'h01); add_byte(8'h7E);
    expect_beat(8'h7E, 1'b1);
    flush(2);
    wait_empty("zero_len");

    // Bit after the last payload bit in the same cycle must not reach the sync register
    add_bit(1'b0); add_frame_hdr(8'h01); add_byte(8'h55);
    add_frame_hdr(8'h01); add_byte(8'h33);
    add_frame_hdr(8'h01); add_byte(8'h44);
    expect_beat(8'h55, 1'b1); expect_beat(8'h44, 1'b1);
    flush(2);
    wait_empty("discard_tail");

    // Overflow: six bytes against a stalled four-entry FIFO
    m_axis_tready = 1'b0;
    add_frame_hdr(8'h06);
    for (int i = 1; i <= 6; i++) add_byte(8'(i));
    for (int i = 1; i <= 4; i++) expect_beat(8'(i), 1'b0);
    flush(2);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'h201);
    check("ovf_frame_done", 32'(frame_active), 32'd0);
    cyc(2'b00, 2'd0); cyc(2'b00, 2'd0);
    check("ovf_hold", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'h201);
    m_axis_tready = 1'b1;
    wait_empty("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Illegal bit count: flagged, no bits consumed
    add_frame_hdr(8'h01);
    bq.pop_back(); bq.pop_back(); bq.pop_back(); bq.pop_back();
    bq.pop_back(); bq.pop_back(); bq.pop_back(); bq.pop_back();
    flush(2);
    check("proto_pre_active", 32'(frame_active), 32'd1);
    check("proto_pre_flag", 32'(proto_err), 32'd0);
    cyc(2'b11, 2'd3);
    check("proto_flag", 32'(proto_err), 32'd1);
    check("proto_active_kept", 32'(frame_active), 32'd1);
    add_byte(8'h01); add_byte(8'h5A);
    expect_beat(8'h5A, 1'b1);
    flush(2);
    wait_empty("proto");
    check("proto_sticky", 32'(proto_err), 32'd1);

    // Asynchronous reset in the middle of a payload
    m_axis_tready = 1'b0;
    add_frame_hdr(8'h03); add_byte(8'hAA);
    add_bit(1'b1); add_bit(1'b1); add_bit(1'b1); add_bit(1'b1);
    flush(2);
    check("mid_active", 32'({frame_active, m_axis_tvalid}), 32'h3);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_outputs", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'd0);
    check("arst_state", 32'({frame_active, overflow, proto_err}), 32'd0);
    @(posedge aclk);
    #1;
    aresetn       = 1'b1;
    m_axis_tready = 1'b1;
    add_frame_hdr(8'h01); add_byte(8'hC7);
    expect_beat(8'hC7, 1'b1);
    flush(2);
    wait_empty("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/man_framer.md
MAN_FRAMER -- requirements
Module: man_framer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hA5C3, the frame sync pattern, MSB received first.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the output FIFO entry count (power of two, 2..16).
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port man_bits, input, 2, decoded Manchester bits; man_bits[0] earlier in time than man_bits[1].
REQ-006 SHALL have port man_bits_n, input, 2, count of valid bits in man_bits (0, 1, 2); value 3 is illegal.
REQ-007 SHALL have port m_axis_tdata, output, 8, payload byte.
REQ-008 SHALL have port m_axis_tvalid, output, 1, byte valid.
REQ-009 SHALL have port m_axis_tready, input, 1, downstream accept.
REQ-010 SHALL have port m_axis_tlast, output, 1, last byte of frame.
REQ-011 SHALL have port frame_active, output, 1, high in LEN or DATA state.
REQ-012 SHALL have port overflow, output, 1, sticky FIFO-overflow flag.
REQ-013 SHALL have port proto_err, output, 1, sticky flag for man_bits_n==3.

Function
REQ-014 SHALL consume the input every cycle with no backpressure; bits used are man_bits[0] only if man_bits_n==1, man_bits[0] then man_bits[1] if man_bits_n==2, none if 0.
REQ-015 SHALL treat man_bits_n==3 as 0 bits and set proto_err.
REQ-016 SHALL process bits strictly serially, so state changes can take effect between the two bits of one cycle.
REQ-017 SHALL implement states HUNT, LEN, DATA; reset state HUNT.
REQ-018 HUNT: each bit shifts into a 16-bit sync register (new bit at LSB); a match with SYNC_WORD after any bit -> LEN, bit counter cleared, and any following bit in the same cycle is the first LEN bit.
REQ-019 Sync register SHALL be cleared to 0 on every entry to HUNT, including at reset.
REQ-020 LEN: 8 bits assembled MSB first into length L; L==0 -> HUNT with no output; otherwise -> DATA with remaining-byte counter = L.
REQ-021 DATA: bits assembled MSB first into bytes; each complete byte is pushed to the FIFO with tlast=1 iff it is byte L; after byte L -> HUNT.
REQ-022 A bit following the last DATA bit in the same cycle SHALL be discarded, not shifted into the sync register.
REQ-023 At most one byte completes per cycle (2 bits per cycle); FIFO write port is single-entry.
REQ-024 FIFO SHALL store {tlast, byte} and be first-word-fall-through: m_axis_tvalid = not empty, tdata/tlast = head entry.
REQ-025 Latency: byte whose final bit arrives at edge N SHALL be visible with tvalid=1 immediately after edge N when FIFO was empty.
REQ-026 Pop occurs on edges where tvalid and tready are both high; tdata/tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-027 Push accepted if FIFO not full, or full with pop on the same edge; simultaneous push and pop leaves occupancy unchanged.
REQ-028 Push with FIFO full and no pop SHALL drop the byte and set overflow; framing (state, counters) continues unaffected, so a dropped tlast byte is lost with the frame still ending.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-030 frame_active SHALL be registered state decode (high during LEN and DATA).

Reset
REQ-031 aresetn low SHALL immediately force: state HUNT, sync register 0, counters 0, FIFO empty, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_active=0, overflow=0, proto_err=0.
REQ-032 Reset mid-frame SHALL discard the partial frame and all FIFO contents; first post-reset bit is treated as a HUNT bit.
REQ-033 overflow and proto_err SHALL clear only on reset.

Verification
REQ-034 Bits A5C3, 02, 11, 22 at 2 bits/cycle, tready=1 -> output 8'h11 tlast=0, then 8'h22 tlast=1; frame_active falls after the last bit.
REQ-035 Same frame at 1 bit/cycle interleaved with man_bits_n=0 cycles -> identical output bytes; sync matched on odd-bit alignment (prefix one junk bit) also detected.
REQ-036 A5C3, 00 -> no output, back to HUNT; an immediately following A5C3, 01, 7E -> single byte 8'h7E tlast=1.
REQ-037 tready=0, frame length 6 -> first 4 bytes held, bytes 5-6 dropped, overflow=1; after tready=1, 4 bytes output, none with tlast.
REQ-038 man_bits_n=3 one cycle -> proto_err=1, no state change; aresetn pulsed low mid-DATA -> all outputs 0 asynchronously, flags cleared.
